// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Serial line and FIFO read-side signals of the UART receiver.
//                slave = receiver side, master = line driver / byte consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int FIFO_AW = 4
);
    logic               rxd;
    logic [7:0]         rdata;
    logic               rvalid;
    logic               rready;
    logic [FIFO_AW:0]   count;
    logic               ferr;
    logic               overrun;

    modport slave (
        input  rxd,
        input  rready,
        output rdata,
        output rvalid,
        output count,
        output ferr,
        output overrun
    );

    modport master (
        output rxd,
        output rready,
        input  rdata,
        input  rvalid,
        input  count,
        input  ferr,
        input  overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : 8N1 UART receiver feeding a first-word fall-through byte
//                FIFO. Framing errors and overruns are reported as pulses.
//                Optional macro UART_RX_FERR_DROP_EN: when defined, bytes with
//                a bad stop bit are discarded instead of stored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_PER_HALF_BIT = 435,
    parameter int FIFO_AW          = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_rx_fifo_if.slave   bus
);

    localparam int                    c_cnt_w     = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [c_cnt_w-1:0]    c_half_last = c_cnt_w'(CLK_PER_HALF_BIT - 1);
    localparam logic [c_cnt_w-1:0]    c_bit_last  = c_cnt_w'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_one   = c_cnt_w'(1);
    localparam logic [FIFO_AW:0]      c_depth     = {1'b1, {FIFO_AW{1'b0}}};
    localparam int                    c_depth_int = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   r_rx_meta;
    logic                   r_rxs;
    logic                   r_rxs_prev;
    logic                   r_ferr;
    logic                   r_overrun;

    logic [7:0]             r_mem [0:c_depth_int-1];
    logic [FIFO_AW-1:0]     r_wr_ptr;
    logic [FIFO_AW-1:0]     r_rd_ptr;
    logic [FIFO_AW:0]       r_count;

    logic                   w_fall;
    logic                   w_stop_sample;
    logic                   w_keep;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_ovr;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta  <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_rx_meta  <= bus.rxd;
            r_rxs      <= r_rx_meta;
            r_rxs_prev <= r_rxs;
        end
    end

    // Only a genuine 1->0 edge arms the receiver; a line stuck low never does
    assign w_fall        = r_rxs_prev & ~r_rxs;
    assign w_stop_sample = (r_state == S_STOP) && (r_cnt == c_bit_last);

`ifdef UART_RX_FERR_DROP_EN
    assign w_keep = w_stop_sample & r_rxs;
`else
    assign w_keep = w_stop_sample;
`endif

    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign w_full = (r_count == c_depth);
    assign w_pop  = (r_count != '0) && bus.rready;
    assign w_push = w_keep && (!w_full || w_pop);
    assign w_ovr  = w_keep && w_full && !w_pop;

    // Receiver FSM: start-bit validation at mid-bit, then full-bit sampling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_ferr    <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt   <= '0;
                        r_state <= r_rxs ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_ferr  <= ~r_rxs;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and overrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_ovr;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Byte storage; contents are only observable through the head pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // Head is forced to zero while empty so rdata is clean out of reset
    assign bus.rdata   = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
    assign bus.rvalid  = (r_count != '0);
    assign bus.count   = r_count;
    assign bus.ferr    = r_ferr;
    assign bus.overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Scoreboard bench for uart_rx_fifo (8 clocks per bit, depth 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int c_half = 4;
    localparam int c_aw   = 2;
    localparam int c_bit  = 2 * c_half;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.FIFO_AW(c_aw)) bus ();

    uart_rx_fifo #(
        .CLK_PER_HALF_BIT (c_half),
        .FIFO_AW          (c_aw)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_vec   = 0;
    int         n_err   = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    logic       ferr_d   = 1'b0;
    logic       ovr_d    = 1'b0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer and pulse-width monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rvalid && bus.rready) begin
                check("pop_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("rdata", bus.rdata, exp_q.pop_front());
                end
            end
            if (bus.ferr) begin
                ferr_cnt++;
                check("ferr_width", ferr_d, 0);
            end
            if (bus.overrun) begin
                ovr_cnt++;
                check("overrun_width", ovr_d, 0);
            end
            ferr_d = bus.ferr;
            ovr_d  = bus.overrun;
        end
    end

    // Drive one 8N1 frame; samples rvalid just before and just after the stop sample
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pop_at_stop,
                              output logic rv_pre, output logic rv_post);
        @(posedge clk); #1 bus.rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (c_bit) @(posedge clk);
            #1 bus.rxd = d[i];
        end
        repeat (c_bit) @(posedge clk);
        #1 bus.rxd = stop;
        repeat (6) @(posedge clk);
        #1;
        rv_pre = bus.rvalid;
        if (pop_at_stop) bus.rready = 1'b1;
        @(posedge clk); #1;
        rv_post = bus.rvalid;
        if (pop_at_stop) bus.rready = 1'b0;
        @(posedge clk); #1 bus.rxd = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic keep);
        logic pre, post;
        if (keep) exp_q.push_back(d);
        send_frame(d, stop, 1'b0, pre, post);
        repeat (c_bit) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.rready = 1'b1;
        repeat (8) @(posedge clk);
        #1 bus.rready = 1'b0;
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_count", bus.count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic pre, post;
        logic keep;
        int   f0, o0;

        rst        = 1'b1;
        bus.rxd    = 1'b1;
        bus.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid",  bus.rvalid,  0);
        check("rst_rdata",   bus.rdata,   0);
        check("rst_count",   bus.count,   0);
        check("rst_ferr",    bus.ferr,    0);
        check("rst_overrun", bus.overrun, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Single byte: latency, head data, occupancy
        f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, pre, post);
        check("a5_rvalid_at_stop", pre, 0);
        check("a5_rvalid_after",   post, 1);
        check("a5_rdata",          bus.rdata, 8'hA5);
        check("a5_count",          bus.count, 1);
        repeat (c_bit) @(posedge clk);
        #1;
        check("a5_ferr",    ferr_cnt - f0, 0);
        check("a5_overrun", ovr_cnt - o0, 0);
        drain();

        // Short low glitch on an idle line
        f0 = ferr_cnt; o0 = ovr_cnt;
        @(posedge clk); #1 bus.rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.rxd = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("glitch_rvalid",  bus.rvalid, 0);
        check("glitch_count",   bus.count, 0);
        check("glitch_ferr",    ferr_cnt - f0, 0);
        check("glitch_overrun", ovr_cnt - o0, 0);

        // Fill past capacity with no reader
        f0 = ferr_cnt; o0 = ovr_cnt;
        for (int v = 1; v <= 5; v++) begin
            send(8'(v), 1'b1, (v <= 4));
        end
        check("ovr_count",   bus.count, 4);
        check("ovr_pulses",  ovr_cnt - o0, 1);
        check("ovr_ferr",    ferr_cnt - f0, 0);
        drain();

        // Full FIFO with a pop on the exact stop-sample cycle
        o0 = ovr_cnt;
        for (int v = 8'h11; v <= 8'h14; v++) begin
            send(8'(v), 1'b1, 1'b1);
        end
        exp_q.push_back(8'h15);
        send_frame(8'h15, 1'b1, 1'b1, pre, post);
        repeat (c_bit) @(posedge clk);
        #1;
        check("simul_count",   bus.count, 4);
        check("simul_overrun", ovr_cnt - o0, 0);
        drain();

        // Framing error
`ifdef UART_RX_FERR_DROP_EN
        keep = 1'b0;
`else
        keep = 1'b1;
`endif
        f0 = ferr_cnt; o0 = ovr_cnt;
        send(8'h3C, 1'b0, keep);
        check("ferr_pulses",  ferr_cnt - f0, 1);
        check("ferr_overrun", ovr_cnt - o0, 0);
        check("ferr_rvalid",  bus.rvalid, keep);
        check("ferr_count",   bus.count, exp_q.size());
        drain();

        // Reset in the middle of data bit 3, then a clean frame
        @(posedge clk); #1 bus.rxd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (c_bit) @(posedge clk);
            #1 bus.rxd = i[0];
        end
        repeat (c_bit + 4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_count", bus.count, 0);
        bus.rxd = 1'b1;
        rst     = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        f0 = ferr_cnt;
        send(8'h7E, 1'b1, 1'b1);
        check("midrst_count_after", bus.count, 1);
        check("midrst_rdata",       bus.rdata, 8'h7E);
        check("midrst_ferr",        ferr_cnt - f0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
